fetch_prefetch_queue: RTL and testbench

Parametrised instruction-fetch front end with a prefetch queue. It issues sequential fetch requests to instruction memory, buffers returned instructions with their PCs in a DEPTH-entry FIFO, and delivers them to decode over a valid/ready handshake. A redirect (jump) retargets fetch, flushes the queue and discards stale in-flight responses. It supersedes the single-register fetch PC stage: the queue replaces the stall input, and the block adds credit-based request throttling.

---
 rtl/fetch_prefetch_queue.sv | 128 ++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues sequential fetch requests, buffers {pc, instr} in a
// DEPTH-entry queue for decode, and retargets on redirect while discarding stale responses.
module fetch_prefetch_queue #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    input  logic            out_ready
);

    localparam int unsigned     AW          = $clog2(DEPTH);
    localparam int unsigned     CW          = AW + 1;
    localparam int unsigned     SW          = CW + 1;
    localparam logic [SW-1:0]   CreditLimit = SW'(DEPTH);
    localparam logic [XLEN-1:0] PcStep      = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    // PC of the oldest in-flight request whose response will be kept.
    logic [XLEN-1:0] live_pc_q, live_pc_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic [XLEN-1:0] redirect_target;
    logic [SW-1:0]   credit_used;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            resp_drop;
    logic            unused_redirect_lsbs;

    assign redirect_target      = {redirect_addr[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_addr[1:0];

    // Dropped responses still hold a credit until they return, so the queue cannot overflow.
    assign credit_used   = {1'b0, occ_q} + {1'b0, outstanding_q};
    assign mem_req_valid = !rst && !redirect && (credit_used < CreditLimit);
    assign mem_req_addr  = fetch_pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign out_valid = !rst && (occ_q != '0);
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_instr = instr_mem[rd_ptr_q];
    assign pop       = out_valid && out_ready;

    assign resp_drop = mem_resp_valid && (drop_q != '0);
    assign push      = mem_resp_valid && !redirect && (drop_q == '0);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        live_pc_d     = live_pc_q;
        occ_d         = occ_q;
        drop_d        = drop_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(mem_resp_valid);

        if (redirect) begin
            fetch_pc_d = redirect_target;
            live_pc_d  = redirect_target;
            occ_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Everything still in flight after this cycle is stale, old drops included.
            drop_d     = outstanding_q - CW'(mem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PcStep;
            end
            if (push) begin
                live_pc_d = live_pc_q + PcStep;
                wr_ptr_d  = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            occ_d = occ_q + CW'(push) - CW'(pop);
            if (resp_drop) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_VECTOR;
            live_pc_q     <= RESET_VECTOR;
            occ_q         <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            live_pc_q     <= live_pc_d;
            occ_q         <= occ_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr_q]    <= live_pc_q;
            instr_mem[wr_ptr_q] <= mem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: fixed-latency in-order memory model plus a scoreboard of
// expected deliveries to decode.
module tb_fetch_prefetch_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data  = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;

    int errors = 0;
    int checks = 0;
    int pops = 0;
    int reqs = 0;
    int mem_lat = 1;
    int mcyc = 0;
    int max_inflight = 0;
    logic [31:0] next_req_addr = RV;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .XLEN        (XLEN),
        .DEPTH       (DEPTH),
        .RESET_VECTOR(RV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_ready     (out_ready)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Memory: accepts at the negedge sample, answers in order mem_lat cycles later.
    always begin
        @(negedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            if (mem_resp_valid && mq.size() > 0) void'(mq.pop_front());
            if (mem_req_valid && mem_req_ready) begin
                mq.push_back('{mem_req_addr, mcyc + mem_lat});
                if (mq.size() > max_inflight) max_inflight = mq.size();
            end
        end
        mcyc++;
        @(posedge clk);
        #1;
        if (mq.size() > 0 && mq[0].due <= mcyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = instr_of(mq[0].addr);
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
    end

    // Request-address model and delivery scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (redirect) begin
                checks++;
                if (mem_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL req_during_redirect: got %b, expected 0", mem_req_valid);
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                checks++;
                if (mem_req_addr !== next_req_addr) begin
                    errors++;
                    $display("FAIL req_addr: got %h, expected %h", mem_req_addr, next_req_addr);
                end
                next_req_addr = next_req_addr + 32'd4;
                reqs++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_delivery: got pc %h, expected none", out_pc);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (out_pc !== e || out_instr !== instr_of(e)) begin
                        errors++;
                        $display("FAIL delivery: got pc %h instr %h, expected pc %h instr %h",
                                 out_pc, out_instr, e, instr_of(e));
                    end
                end
                pops++;
            end
        end
    end

    task automatic do_reset(input int lat);
        @(posedge clk);
        #1;
        rst = 1'b1;
        redirect = 1'b0;
        out_ready = 1'b0;
        mem_req_ready = 1'b1;
        mem_lat = lat;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        pops = 0;
        reqs = 0;
        next_req_addr = RV;
        rst = 1'b0;
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_pops(input int target, input int budget);
        int n = 0;
        while (pops < target && n < budget) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (pops < target) begin
            errors++;
            $display("FAIL pop_timeout: got %0d deliveries, expected %0d", pops, target);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect = 1'b0;
        out_ready = 1'b0;
        mem_req_ready = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got req %b out %b, expected 0 0", mem_req_valid, out_valid);
        end
        step();
        exp_q.delete();
        next_req_addr = RV;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RV) begin
            errors++;
            $display("FAIL first_req: got %b %h, expected 1 %h", mem_req_valid, mem_req_addr, RV);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_out_valid: got %b, expected 0", out_valid);
        end
    endtask

    task automatic test_stream();
        do_reset(1);
        out_ready = 1'b1;
        push_seq(RV, 10);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                checks++;
                if (out_valid !== (c >= 2)) begin
                    errors++;
                    $display("FAIL throughput c%0d: got %b, expected %b", c, out_valid, c >= 2);
                end
            end
            step();
        end
        run_until_pops(10, 20);
    endtask

    task automatic test_backpressure();
        do_reset(1);
        push_seq(RV, 8);
        repeat (10) step();
        checks++;
        if (reqs !== 4) begin
            errors++;
            $display("FAIL credit_limit: got %0d requests, expected 4", reqs);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_stall: got %b, expected 0", mem_req_valid);
        end
        step();
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h110) begin
            errors++;
            $display("FAIL resume: got %b %h, expected 1 00000110", mem_req_valid, mem_req_addr);
        end
        step();
        out_ready = 1'b1;
        run_until_pops(8, 40);
    endtask

    task automatic test_redirect();
        do_reset(3);
        step();
        step();
        mem_req_ready = 1'b0;
        redirect = 1'b1;
        redirect_addr = 32'h2002;
        next_req_addr = 32'h2000;
        @(negedge clk);
        step();
        redirect = 1'b0;
        mem_req_ready = 1'b1;
        out_ready = 1'b1;
        push_seq(32'h2000, 6);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2000) begin
            errors++;
            $display("FAIL post_redirect: got out %b req %b %h, expected 0 1 00002000",
                     out_valid, mem_req_valid, mem_req_addr);
        end
        run_until_pops(6, 40);
    endtask

    task automatic test_redirect_pop();
        do_reset(1);
        out_ready = 1'b1;
        push_seq(RV, 4);
        repeat (5) step();
        redirect = 1'b1;
        redirect_addr = 32'h3000;
        next_req_addr = 32'h3000;
        push_seq(32'h3000, 4);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h10C) begin
            errors++;
            $display("FAIL redirect_pop_head: got %b %h, expected 1 0000010c", out_valid, out_pc);
        end
        step();
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3000) begin
            errors++;
            $display("FAIL redirect_pop_flush: got out %b req %b %h, expected 0 1 00003000",
                     out_valid, mem_req_valid, mem_req_addr);
        end
        run_until_pops(8, 40);
    endtask

    task automatic test_wrap();
        do_reset(1);
        out_ready = 1'b1;
        redirect = 1'b1;
        redirect_addr = 32'hFFFF_FFF8;
        next_req_addr = 32'hFFFF_FFF8;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        step();
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL wrap_start: got %b %h, expected 1 fffffff8", mem_req_valid, mem_req_addr);
        end
        run_until_pops(4, 30);
    endtask

    task automatic test_reset_mid();
        do_reset(3);
        repeat (5) step();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got out %b req %b, expected 0 0", out_valid, mem_req_valid);
        end
        step();
        next_req_addr = RV;
        pops = 0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== RV) begin
            errors++;
            $display("FAIL mid_reset_restart: got out %b req %b %h, expected 0 1 %h",
                     out_valid, mem_req_valid, mem_req_addr, RV);
        end
        step();
        out_ready = 1'b1;
        push_seq(RV, 4);
        run_until_pops(4, 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirect_addr = '0;
        out_ready = 1'b0;
        mem_req_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_reset_mid();
        checks++;
        if (max_inflight > int'(DEPTH)) begin
            errors++;
            $display("FAIL inflight_bound: got %0d, expected at most %0d", max_inflight, DEPTH);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
